async_fork_fifo: RTL and testbench

//  Buffered fan-out node for the async req/ack dataflow fabric.
//  - Upstream: acts as initiator. Pulls tokens from a producer-style responder.
//  - Downstream: acts as responder to NUM_OUT independent consumer-style initiators.
//  - Each token is delivered exactly once to every output. Outputs are served independently.
//  - Replaces the lock-step AND-of-req_r fork: a slow consumer stalls the others only once DEPTH tokens are outstanding.

---
 rtl/async_fork_fifo_pkg.sv | 29 ++
 rtl/async_fork_read_port.sv | 51 +++++
 rtl/async_fork_fifo.sv | 133 +++++++++++++
 tb/tb_async_fork_fifo.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_fork_fifo_pkg.sv
// Shared helpers for the async fork FIFO: upstream FSM encoding and pointer sizing.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package async_fork_fifo_pkg;

    // Upstream initiator: either idle or holding one outstanding request.
    typedef enum logic [0:0] {
        UP_IDLE = 1'b0,
        UP_REQ  = 1'b1
    } up_state_t;

    // Constant-foldable ceil(log2(value)); used for address and pointer widths.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    function automatic int ptr_width(input int depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/async_fork_read_port.sv
// One downstream responder port: own read pointer, one-cycle ack pulse, held data.
// Latency: token written at edge N is acked at edge N+1 at the earliest.
// Backpressure: acks only while req is high and this port's view is non-empty; max one token per 2 cycles.
//
// Ports: clk/rst (sync, active-high); i_req from consumer; i_wr_ptr shared write pointer;
//        i_rd_word = mem word at this port's read address; o_rd_ptr, o_ack, o_dout.
module async_fork_read_port
    import async_fork_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PTR_W      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [PTR_W-1:0]      i_wr_ptr,
    input  logic [DATA_WIDTH-1:0] i_rd_word,
    output logic [PTR_W-1:0]      o_rd_ptr,
    output logic                  o_ack,
    output logic [DATA_WIDTH-1:0] o_dout
);

    logic [PTR_W-1:0]      r_rd_ptr;
    logic                  r_ack;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  w_empty;

    // Registered pointers only: a token written this cycle is not visible until next cycle.
    assign w_empty = (i_wr_ptr == r_rd_ptr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_ack    <= 1'b0;
            r_dout   <= '0;
        end else begin
            r_ack <= 1'b0;
            // The ~r_ack term forces a gap cycle after every ack.
            if (i_req && !r_ack && !w_empty) begin
                r_ack    <= 1'b1;
                r_dout   <= i_rd_word;
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    assign o_rd_ptr = r_rd_ptr;
    assign o_ack    = r_ack;
    assign o_dout   = r_dout;

endmodule

// File: rtl/async_fork_fifo.sv
// Buffered fan-out: pulls tokens from upstream, delivers each once to every one of NUM_OUT ports.
// Latency: ack_l at edge N -> earliest ack_r at N+1; slowest port frees full buffer at N -> req_l at N+1.
// Backpressure: req_l withheld while the slowest port has DEPTH tokens pending; ports drain independently.
//
// Ports: clk, rst (sync, active-high); req_l/ack_l/din upstream initiator side;
//        req_r/ack_r/dout per-port responder side (port i = dout[DATA_WIDTH*i +: DATA_WIDTH]);
//        level = max pending over ports; stray_ack = sticky ack_l-without-req_l flag.
module async_fork_fifo
    import async_fork_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_OUT    = 2,
    parameter int DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          req_l,
    input  logic                          ack_l,
    input  logic [DATA_WIDTH-1:0]         din,
    input  logic [NUM_OUT-1:0]            req_r,
    output logic [NUM_OUT-1:0]            ack_r,
    output logic [DATA_WIDTH*NUM_OUT-1:0] dout,
    output logic [clog2(DEPTH):0]         level,
    output logic                          stray_ack
);

    localparam int ADDR_W = clog2(DEPTH);
    localparam int PTR_W  = ptr_width(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    up_state_t             r_state;
    up_state_t             w_state_nxt;
    logic                  w_write;
    logic                  r_stray;

    logic [PTR_W-1:0]      w_rd_ptr  [NUM_OUT];
    logic [PTR_W-1:0]      w_pend    [NUM_OUT];
    logic [DATA_WIDTH-1:0] w_rd_word [NUM_OUT];
    logic [PTR_W-1:0]      w_level;
    logic                  w_full;

    // Read ports
    for (genvar g = 0; g < NUM_OUT; g++) begin : g_port
        assign w_rd_word[g] = r_mem[w_rd_ptr[g][ADDR_W-1:0]];
        assign w_pend[g]    = r_wr_ptr - w_rd_ptr[g];

        async_fork_read_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .PTR_W      (PTR_W)
        ) u_read_port (
            .clk       (clk),
            .rst       (rst),
            .i_req     (req_r[g]),
            .i_wr_ptr  (r_wr_ptr),
            .i_rd_word (w_rd_word[g]),
            .o_rd_ptr  (w_rd_ptr[g]),
            .o_ack     (ack_r[g]),
            .o_dout    (dout[DATA_WIDTH*g +: DATA_WIDTH])
        );
    end

    // Occupancy is set by the slowest port; a slot frees only once all ports pass it.
    always_comb begin
        w_level = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (w_pend[i] > w_level) begin
                w_level = w_pend[i];
            end
        end
    end

    assign w_full = (w_level == PTR_W'(DEPTH));
    assign level  = w_level;

    // Upstream initiator FSM: at most one request outstanding, so a granted
    // request always has a free slot even if full was close.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= UP_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_write     = 1'b0;
        case (r_state)
            UP_IDLE: begin
                // Do not raise req_l in the same cycle as a stray ack.
                if (!w_full && !ack_l) begin
                    w_state_nxt = UP_REQ;
                end
            end
            UP_REQ: begin
                if (ack_l) begin
                    w_write     = 1'b1;
                    w_state_nxt = UP_IDLE;
                end
            end
            default: w_state_nxt = UP_IDLE;
        endcase
    end

    assign req_l = (r_state == UP_REQ);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
        end else if (w_write) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
    end

    // Buffer contents are don't-care after reset, so no reset on the array.
    always_ff @(posedge clk) begin
        if (!rst && w_write) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stray <= 1'b0;
        end else if (ack_l && (r_state == UP_IDLE)) begin
            r_stray <= 1'b1;
        end
    end

    assign stray_ack = r_stray;

endmodule

// File: tb/tb_async_fork_fifo.sv
`timescale 1ns/1ps
module tb_async_fork_fifo;
    localparam int DW    = 32;
    localparam int NO    = 2;
    localparam int DEPTH = 4;
    localparam int LW    = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_l;
    logic             ack_l = 1'b0;
    logic [DW-1:0]    din = '0;
    logic [NO-1:0]    req_r = '0;
    logic [NO-1:0]    ack_r;
    logic [DW*NO-1:0] dout;
    logic [LW-1:0]    level;
    logic             stray_ack;

    always #5 clk = ~clk;

    async_fork_fifo #(.DATA_WIDTH(DW), .NUM_OUT(NO), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_l     (req_l),
        .ack_l     (ack_l),
        .din       (din),
        .req_r     (req_r),
        .ack_r     (ack_r),
        .dout      (dout),
        .level     (level),
        .stray_ack (stray_ack)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Stimulus knobs (written only by the main sequence)
    bit          prod_on    = 1'b0;
    int          prod_stall = 0;
    int          cons_stall = 0;
    bit [NO-1:0] hold_low   = '0;
    int          rst_req    = 0;
    int          shot_req   = 0;
    logic [DW-1:0] shot_val = '0;
    int          stray_req  = 0;

    // Behavioural model: the stream of accepted tokens plus per-port consumed counts.
    logic [DW-1:0] hist [$];
    int            wr_cnt = 0;
    int            rd_cnt [NO];
    bit            m_req   = 1'b0;
    bit            m_stray = 1'b0;
    logic [NO-1:0] m_ack   = '0;
    logic [DW-1:0] m_dout  [NO];

    // Bookkeeping (written only by the cycle process)
    int            rst_done = 0, shot_done = 0, stray_done = 0;
    int            next_tok = 0;
    int            tok_at_reset = 0;
    int            recv_cnt [NO];
    int            ack_total [NO];
    bit [NO-1:0]   first_pend = '1;
    logic [DW-1:0] first_val [NO];

    initial begin
        for (int i = 0; i < NO; i++) begin
            rd_cnt[i] = 0; m_dout[i] = '0; recv_cnt[i] = 0; ack_total[i] = 0; first_val[i] = '0;
        end
    end

    function automatic int model_level();
        int mx;
        mx = 0;
        for (int i = 0; i < NO; i++) begin
            if (wr_cnt - rd_cnt[i] > mx) mx = wr_cnt - rd_cnt[i];
        end
        return mx;
    endfunction

    // One process per cycle: compare outputs settled after the last posedge, then drive
    // the next inputs and advance the model to what the next posedge must produce.
    always @(negedge clk) begin
        bit full;
        check("req_l", req_l, m_req);
        check("stray_ack", stray_ack, m_stray);
        check("level", level, model_level());
        check("level_le_depth", level <= DEPTH, 1);
        check("ack_r", ack_r, m_ack);
        for (int i = 0; i < NO; i++) begin
            check($sformatf("dout%0d", i), dout[i*DW +: DW], m_dout[i]);
            if (ack_r[i]) begin
                recv_cnt[i]++;
                ack_total[i]++;
                if (first_pend[i]) begin
                    first_val[i]  = dout[i*DW +: DW];
                    first_pend[i] = 1'b0;
                end
            end
        end

        for (int i = 0; i < NO; i++) begin
            req_r[i] = !hold_low[i] && ($urandom_range(99) >= cons_stall);
        end

        if (rst_done != rst_req) begin
            rst_done++;
            rst   = 1'b1;
            ack_l = 1'($urandom_range(1));
            din   = $urandom;
            hist.delete();
            wr_cnt  = 0;
            m_req   = 1'b0;
            m_stray = 1'b0;
            m_ack   = '0;
            for (int i = 0; i < NO; i++) begin
                rd_cnt[i] = 0; m_dout[i] = '0;
            end
            first_pend   = '1;
            tok_at_reset = next_tok;
        end else begin
            rst   = 1'b0;
            ack_l = 1'b0;
            if (m_req) begin
                if (shot_done != shot_req) begin
                    shot_done++;
                    ack_l = 1'b1; din = shot_val;
                end else if (prod_on && $urandom_range(99) >= prod_stall) begin
                    ack_l = 1'b1; din = next_tok; next_tok++;
                end
            end else if (stray_done != stray_req) begin
                stray_done++;
                ack_l = 1'b1; din = $urandom;
            end

            full = (model_level() == DEPTH);
            for (int i = 0; i < NO; i++) begin
                if (req_r[i] && !m_ack[i] && wr_cnt > rd_cnt[i]) begin
                    m_ack[i]  = 1'b1;
                    m_dout[i] = hist[rd_cnt[i]];
                    rd_cnt[i]++;
                end else begin
                    m_ack[i] = 1'b0;
                end
            end
            if (ack_l && m_req) begin
                hist.push_back(din); wr_cnt++; m_req = 1'b0;
            end else if (ack_l) begin
                m_stray = 1'b1;
            end else if (!m_req && !full) begin
                m_req = 1'b1;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, b1, guard, a0, a1;
        bit found;
        step(2);

        // 1: full-rate streaming, both consumers always requesting
        prod_on = 1'b1; prod_stall = 0; cons_stall = 0;
        guard = 0;
        while ((recv_cnt[0] < 100 || recv_cnt[1] < 100) && guard < 1000) begin step(1); guard++; end
        check("t1_done", guard < 1000, 1);
        check("t1_first0", first_val[0], 0);
        check("t1_first1", first_val[1], 0);
        a0 = ack_total[0]; a1 = ack_total[1];
        step(40);
        check("t1_rate0", ack_total[0] - a0, 20);
        check("t1_rate1", ack_total[1] - a1, 20);

        // 2 + 5: slow port1 fills the buffer; stray ack while req_l is low
        prod_on = 1'b0; hold_low = 2'b10; rst_req++;
        step(3);
        b0 = recv_cnt[0]; b1 = recv_cnt[1];
        prod_on = 1'b1;
        step(40);
        check("t2_port0_count", recv_cnt[0] - b0, 4);
        check("t2_level", level, 4);
        check("t2_req_l", req_l, 0);
        stray_req++;
        step(2);
        check("t5_stray", stray_ack, 1);
        check("t5_level", level, 4);
        step(5);
        check("t5_stray_sticky", stray_ack, 1);
        hold_low = '0;
        step(30);
        check("t2_port1_first", first_val[1], tok_at_reset);
        check("t2_port0_first", first_val[0], tok_at_reset);
        check("t2_port1_resumed", recv_cnt[1] - b1 >= 8, 1);
        check("t2_port0_resumed", recv_cnt[0] - b0 > 4, 1);

        // 3: single token into an empty buffer
        prod_on = 1'b0; rst_req++;
        step(4);
        shot_val = 32'hA5; shot_req++;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            step(1);
            if (ack_l) found = 1'b1;
        end
        check("t3_ack_l_seen", found, 1);
        check("t3_ack_r_edgeN", ack_r, 0);
        check("t3_level_edgeN", level, 1);
        step(1);
        check("t3_ack_r_edgeN1", ack_r, 2'b11);
        check("t3_dout0", dout[DW-1:0], 32'hA5);
        check("t3_dout1", dout[2*DW-1:DW], 32'hA5);
        check("t3_level_drained", level, 0);

        // 4: reset mid-stream with tokens buffered
        hold_low = 2'b10; prod_on = 1'b1;
        guard = 0;
        while (level != 3 && guard < 50) begin step(1); guard++; end
        check("t4_reached_l3", guard < 50, 1);
        prod_on = 1'b0;
        step(3);
        rst_req++;
        step(1);
        check("t4_req_l", req_l, 0);
        check("t4_ack_r", ack_r, 0);
        check("t4_dout", dout, 0);
        check("t4_level", level, 0);
        check("t4_stray", stray_ack, 0);
        hold_low = '0; prod_on = 1'b1;
        step(30);
        check("t4_first0", first_val[0], tok_at_reset);
        check("t4_first1", first_val[1], tok_at_reset);

        // 6: random stalls everywhere, 5000 tokens per port
        prod_stall = 30; cons_stall = 30;
        b0 = recv_cnt[0]; b1 = recv_cnt[1];
        guard = 0;
        while ((recv_cnt[0] - b0 < 5000 || recv_cnt[1] - b1 < 5000) && guard < 60000) begin
            step(1); guard++;
        end
        check("t6_done", guard < 60000, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
